// File: rtl/stage_sequencer.sv
// Stage sequencer for the multi-cycle processor: steps Fetch(1) .. Write Back(5), idle/halted as 0.
// Handles run/single-step start, Memory-stage stalls with a timeout, sticky halt and retire counting.
module stage_sequencer #(
  parameter int COUNT_W  = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Run,
  input  logic               Step,
  input  logic               Halt_Request,
  input  logic               Mem_Wait,
  output logic [2:0]         Stage,
  output logic               Instr_Done,
  output logic [COUNT_W-1:0] Instr_Count,
  output logic               Halted,
  output logic               Mem_Timeout
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [7:0]         MAX_WAIT_C = 8'(MAX_WAIT);
  localparam logic [COUNT_W-1:0] COUNT_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_t             state_r, state_s;
  logic [2:0]         stage_r, stage_s;
  logic               step_flag_r, step_flag_s;
  logic               halt_latch_r, halt_latch_s;
  logic [7:0]         stall_cnt_r, stall_cnt_s;
  logic [COUNT_W-1:0] count_r, count_s;
  logic               done_r, done_s;
  logic               halted_r, halted_s;
  logic               timeout_r, timeout_s;

  // State and output registers; reset abandons any in-flight instruction
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r      <= ST_IDLE;
      stage_r      <= 3'd0;
      step_flag_r  <= 1'b0;
      halt_latch_r <= 1'b0;
      stall_cnt_r  <= 8'd0;
      count_r      <= '0;
      done_r       <= 1'b0;
      halted_r     <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      stage_r      <= stage_s;
      step_flag_r  <= step_flag_s;
      halt_latch_r <= halt_latch_s;
      stall_cnt_r  <= stall_cnt_s;
      count_r      <= count_s;
      done_r       <= done_s;
      halted_r     <= halted_s;
      timeout_r    <= timeout_s;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_s      = state_r;
    stage_s      = stage_r;
    step_flag_s  = step_flag_r;
    halt_latch_s = halt_latch_r;
    stall_cnt_s  = stall_cnt_r;
    count_s      = count_r;
    done_s       = 1'b0;
    halted_s     = halted_r;
    timeout_s    = timeout_r;

    case (state_r)
      ST_IDLE: begin
        stage_s = 3'd0;
        if (Run) begin
          state_s     = ST_ACTIVE;
          stage_s     = 3'd1;
          step_flag_s = 1'b0;
        end else if (Step) begin
          state_s     = ST_ACTIVE;
          stage_s     = 3'd1;
          step_flag_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_ACTIVE: begin
        case (stage_r)
          3'd1: stage_s = 3'd2;
          3'd2: begin
            stage_s      = 3'd3;
            halt_latch_s = Halt_Request;
          end
          3'd3: stage_s = 3'd4;
          3'd4: begin
            // The stall counter holds completed stall cycles; a further wait past the limit is forced through
            if (Mem_Wait && (stall_cnt_r == MAX_WAIT_C)) begin
              stage_s     = 3'd5;
              timeout_s   = 1'b1;
              stall_cnt_s = 8'd0;
            end else if (Mem_Wait) begin
              stage_s     = 3'd4;
              stall_cnt_s = stall_cnt_r + 8'd1;
            end else begin
              stage_s     = 3'd5;
              stall_cnt_s = 8'd0;
            end
          end
          3'd5: begin
            count_s     = count_r + COUNT_ONE;
            done_s      = 1'b1;
            stall_cnt_s = 8'd0;
            if (halt_latch_r) begin
              state_s  = ST_HALTED;
              stage_s  = 3'd0;
              halted_s = 1'b1;
            end else if (step_flag_r || !Run) begin
              state_s = ST_IDLE;
              stage_s = 3'd0;
            end else begin
              stage_s = 3'd1;
            end
          end
          default: begin
            state_s = ST_IDLE;
            stage_s = 3'd0;
          end
        endcase
      end

      ST_HALTED: begin
        stage_s  = 3'd0;
        halted_s = 1'b1;
      end

      default: begin
        state_s = ST_IDLE;
        stage_s = 3'd0;
      end
    endcase
  end

  assign Stage       = stage_r;
  assign Instr_Done  = done_r;
  assign Instr_Count = count_r;
  assign Halted      = halted_r;
  assign Mem_Timeout = timeout_r;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: expected per-cycle outputs are queued when stimulus
// is applied and popped/compared one cycle later, just after the clock edge.
module tb_stage_sequencer;

  localparam int CW = 4;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          Run = 1'b0;
  logic          Step = 1'b0;
  logic          Halt_Request = 1'b0;
  logic          Mem_Wait = 1'b0;
  logic [2:0]    Stage;
  logic          Instr_Done;
  logic [CW-1:0] Instr_Count;
  logic          Halted;
  logic          Mem_Timeout;

  stage_sequencer #(.COUNT_W(CW), .MAX_WAIT(8)) dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .Step(Step),
    .Halt_Request(Halt_Request), .Mem_Wait(Mem_Wait),
    .Stage(Stage), .Instr_Done(Instr_Done), .Instr_Count(Instr_Count),
    .Halted(Halted), .Mem_Timeout(Mem_Timeout)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [2:0]    stage;
    logic          done;
    logic [CW-1:0] count;
    logic          halted;
    logic          timeout;
    string         tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   ec = 0;          // expected retired count (bench-side)
  logic hl = 1'b0;       // expected Halted
  logic to = 1'b0;       // expected Mem_Timeout

  task automatic cmp(input string tag, input string field, input logic [7:0] got, input logic [7:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s.%s got %0d want %0d", tag, field, got, want);
    end
  endtask

  // One clock: queue the expectation for this edge, advance, then pop and compare.
  task automatic exp(input logic [2:0] st, input logic dn, input string tag);
    exp_t e;
    logic [31:0] ecv;
    ecv = ec;
    e.stage = st; e.done = dn; e.count = ecv[CW-1:0];
    e.halted = hl; e.timeout = to; e.tag = tag;
    q.push_back(e);
    @(posedge Clock);
    #1;
    Step = 1'b0;
    Halt_Request = 1'b0;
    e = q.pop_front();
    cmp(e.tag, "stage", {5'd0, Stage}, {5'd0, e.stage});
    cmp(e.tag, "done", {7'd0, Instr_Done}, {7'd0, e.done});
    cmp(e.tag, "count", {4'd0, Instr_Count}, {4'd0, e.count});
    cmp(e.tag, "halted", {7'd0, Halted}, {7'd0, e.halted});
    cmp(e.tag, "timeout", {7'd0, Mem_Timeout}, {7'd0, e.timeout});
  endtask

  // Expect one full instruction (stages 1..5); optional stalls, forced stall timeout,
  // and one-cycle Step/Halt_Request pulses raised during a chosen stage.
  task automatic instr(input int waits, input logic done1, input int step_at, input int halt_at,
                       input logic forced, input string tag);
    for (int s = 1; s <= 4; s++) begin
      exp(3'(s), (s == 1) ? done1 : 1'b0, $sformatf("%s_s%0d", tag, s));
      if (s == step_at) Step = 1'b1;
      if (s == halt_at) Halt_Request = 1'b1;
    end
    Mem_Wait = (waits > 0);
    for (int i = 0; i < waits; i++) exp(3'd4, 1'b0, $sformatf("%s_stall%0d", tag, i));
    if (forced) to = 1'b1;
    else Mem_Wait = 1'b0;
    exp(3'd5, 1'b0, $sformatf("%s_s5", tag));
  endtask

  initial begin
    // reset state
    exp(3'd0, 1'b0, "reset0");
    exp(3'd0, 1'b0, "reset1");

    // back-to-back run; Halt_Request outside stage 2 is ignored
    Reset = 1'b0;
    Run = 1'b1;
    instr(0, 1'b0, 0, 0, 1'b0, "run1");
    ec = 1;
    instr(0, 1'b1, 0, 4, 1'b0, "run2");
    ec = 2;
    // three stall cycles in Memory
    instr(3, 1'b1, 0, 1, 1'b0, "stall3");
    Run = 1'b0;
    ec = 3;
    exp(3'd0, 1'b1, "run_stop");
    exp(3'd0, 1'b0, "idle_hold");

    // single step; second pulse in stage 3 ignored
    Step = 1'b1;
    instr(0, 1'b0, 3, 0, 1'b0, "step");
    ec = 4;
    exp(3'd0, 1'b1, "step_ret");
    exp(3'd0, 1'b0, "step_idle0");
    exp(3'd0, 1'b0, "step_idle1");

    // Run and Step together: run wins, then halt during stage 2 of the third instruction
    Run = 1'b1;
    Step = 1'b1;
    instr(0, 1'b0, 0, 0, 1'b0, "both");
    ec = 5;
    instr(0, 1'b1, 0, 0, 1'b0, "b2");
    ec = 6;
    instr(0, 1'b1, 0, 2, 1'b0, "b3halt");
    ec = 7;
    hl = 1'b1;
    exp(3'd0, 1'b1, "halt_ret");
    Step = 1'b1;
    exp(3'd0, 1'b0, "halt_ign0");
    exp(3'd0, 1'b0, "halt_ign1");
    exp(3'd0, 1'b0, "halt_ign2");

    // reset clears halt; then stall timeout twice (counter cleared between)
    Reset = 1'b1;
    ec = 0;
    hl = 1'b0;
    exp(3'd0, 1'b0, "rst_halt");
    Reset = 1'b0;
    instr(8, 1'b0, 0, 0, 1'b1, "tmo1");
    ec = 1;
    instr(8, 1'b1, 0, 0, 1'b1, "tmo2");
    Mem_Wait = 1'b0;
    ec = 2;

    // counter wrap at 2^CW
    while (ec <= 16) begin
      instr(0, 1'b1, 0, 0, 1'b0, $sformatf("wrap%0d", ec));
      ec++;
    end
    exp(3'd1, 1'b1, "post_wrap_s1");
    exp(3'd2, 1'b0, "post_wrap_s2");
    exp(3'd3, 1'b0, "post_wrap_s3");

    // reset mid-instruction: abandoned, no retire
    Reset = 1'b1;
    Run = 1'b0;
    ec = 0;
    to = 1'b0;
    exp(3'd0, 1'b0, "rst_mid");
    Reset = 1'b0;
    exp(3'd0, 1'b0, "rst_mid_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
